// File: rtl/ssd_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with frame-synchronous digit update.
// Optional leading-zero blanking of displayed digits when LEADING_ZERO_BLANK_EN is defined.
module ssd_scan_ctrl #(
    parameter int unsigned DIV_MAX = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits,
    input  logic        load,
    output logic [3:0]  ssd_in,
    output logic [3:0]  ssd_ctl,
    output logic        frame_done
);

    localparam int unsigned DivW = $clog2(DIV_MAX);
    localparam logic [DivW-1:0] DivLast = DivW'(DIV_MAX - 1);

    logic [DivW-1:0] div_q, div_d;
    logic [1:0]      idx_q, idx_d;
    logic [15:0]     disp_q, disp_d;
    logic [15:0]     pend_q, pend_d;
    logic            pend_valid_q, pend_valid_d;
    logic [3:0]      ssd_in_q, ssd_in_d;
    logic [3:0]      ssd_ctl_q, ssd_ctl_d;
    logic            frame_done_q, frame_done_d;
    logic            tick;
    logic            wrap;

`ifdef LEADING_ZERO_BLANK_EN
    // Blank a zero digit only if every digit to its left is also blank; digit 0 always shows.
    function automatic logic [15:0] to_disp(input logic [15:0] v);
        logic        b3, b2, b1;
        logic [15:0] r;
        b3 = (v[15:12] == 4'd0);
        b2 = b3 && (v[11:8] == 4'd0);
        b1 = b2 && (v[7:4] == 4'd0);
        r  = v;
        if (b3) r[15:12] = 4'hF;
        if (b2) r[11:8]  = 4'hF;
        if (b1) r[7:4]   = 4'hF;
        return r;
    endfunction
`else
    function automatic logic [15:0] to_disp(input logic [15:0] v);
        return v;
    endfunction
`endif

    always_comb begin
        tick         = (div_q == DivLast);
        wrap         = tick && (idx_q == 2'd3);
        div_d        = tick ? '0 : div_q + DivW'(1);
        idx_d        = tick ? idx_q + 2'd1 : idx_q;
        disp_d       = disp_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        frame_done_d = wrap;

        // disp only moves at the frame wrap so a frame never mixes old and new digits.
        if (wrap) begin
            if (load) begin
                disp_d = to_disp(digits);
            end else if (pend_valid_q) begin
                disp_d = to_disp(pend_q);
            end
            pend_valid_d = 1'b0;
        end else if (load) begin
            pend_d       = digits;
            pend_valid_d = 1'b1;
        end

        // Use disp_d so digit 0 on the wrap edge already shows the new frame.
        ssd_ctl_d = tick ? ~(4'b0001 << idx_d) : ssd_ctl_q;
        ssd_in_d  = tick ? disp_d[{idx_d, 2'b00} +: 4] : ssd_in_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q        <= '0;
            idx_q        <= 2'd0;
            disp_q       <= 16'hFFFF;
            pend_q       <= 16'hFFFF;
            pend_valid_q <= 1'b0;
            ssd_in_q     <= 4'd15;
            ssd_ctl_q    <= 4'b1110;
            frame_done_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            ssd_in_q     <= ssd_in_d;
            ssd_ctl_q    <= ssd_ctl_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign ssd_in     = ssd_in_q;
    assign ssd_ctl    = ssd_ctl_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl with DIV_MAX=4 (tick every 4 cycles, wrap every 16).
// Expected blank digits follow LEADING_ZERO_BLANK_EN when it is defined.
module tb_ssd_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits = 16'h0;
    logic        load = 1'b0;
    logic [3:0]  ssd_in;
    logic [3:0]  ssd_ctl;
    logic        frame_done;

    int checks = 0;
    int failures = 0;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [3:0] BZ = 4'd15;
`else
    localparam logic [3:0] BZ = 4'd0;
`endif

    ssd_scan_ctrl #(.DIV_MAX(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .load       (load),
        .ssd_in     (ssd_in),
        .ssd_ctl    (ssd_ctl),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned idle;
        logic        rst;
        logic        load;
        logic [15:0] digits;
        logic [3:0]  ctl;
        logic [3:0]  in;
        logic        fd;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input int unsigned idle, input logic r, input logic l,
                                input logic [15:0] d, input logic [3:0] c,
                                input logic [3:0] i, input logic f);
        vec_t v;
        v.idle = idle; v.rst = r; v.load = l; v.digits = d;
        v.ctl = c; v.in = i; v.fd = f;
        vq.push_back(v);
    endfunction

    task automatic step(input logic r, input logic l, input logic [15:0] d);
        rst = r;
        load = l;
        digits = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int tag, input logic [3:0] act,
                       input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0d: got %b expected %b", nm, tag, act, exp);
        end
    endtask

    task automatic chk_all(input int tag, input logic [3:0] c, input logic [3:0] i,
                           input logic f);
        chk("ssd_ctl", tag, ssd_ctl, c);
        chk("ssd_in", tag, ssd_in, i);
        chk("frame_done", tag, {3'b000, frame_done}, {3'b000, f});
    endtask

    initial begin
        // Edges after reset release: tick at k=4n, wrap at k=16n.
        add(0, 0, 1, 16'h1234, 4'b1011, 4'd15, 0);  // k=41 load mid-frame
        add(2, 0, 0, 16'h0,    4'b0111, 4'd15, 0);  // k=44 old digits still shown
        add(3, 0, 0, 16'h0,    4'b1110, 4'd4,  1);  // k=48 wrap
        add(0, 0, 0, 16'h0,    4'b1110, 4'd4,  0);  // k=49 pulse is one cycle
        add(2, 0, 0, 16'h0,    4'b1101, 4'd3,  0);
        add(3, 0, 0, 16'h0,    4'b1011, 4'd2,  0);
        add(3, 0, 0, 16'h0,    4'b0111, 4'd1,  0);
        add(3, 0, 1, 16'h5678, 4'b1110, 4'd8,  1);  // k=64 load on the wrap edge
        add(3, 0, 0, 16'h0,    4'b1101, 4'd7,  0);
        add(3, 0, 0, 16'h0,    4'b1011, 4'd6,  0);
        add(3, 0, 0, 16'h0,    4'b0111, 4'd5,  0);
        add(0, 0, 1, 16'h1111, 4'b0111, 4'd5,  0);  // k=77
        add(0, 0, 1, 16'h2222, 4'b0111, 4'd5,  0);  // k=78 last load wins
        add(1, 0, 0, 16'h0,    4'b1110, 4'd2,  1);  // k=80
        add(3, 0, 0, 16'h0,    4'b1101, 4'd2,  0);
        add(3, 0, 0, 16'h0,    4'b1011, 4'd2,  0);
        add(3, 0, 0, 16'h0,    4'b0111, 4'd2,  0);
        add(0, 0, 1, 16'h0070, 4'b0111, 4'd2,  0);  // k=93
        add(2, 0, 0, 16'h0,    4'b1110, 4'd0,  1);  // k=96
        add(3, 0, 0, 16'h0,    4'b1101, 4'd7,  0);
        add(3, 0, 0, 16'h0,    4'b1011, BZ,    0);
        add(3, 0, 0, 16'h0,    4'b0111, BZ,    0);
        add(0, 0, 1, 16'h0000, 4'b0111, BZ,    0);  // k=109
        add(2, 0, 0, 16'h0,    4'b1110, 4'd0,  1);  // k=112 digit 0 never blanked
        add(3, 0, 0, 16'h0,    4'b1101, BZ,    0);
        add(3, 0, 0, 16'h0,    4'b1011, BZ,    0);
        add(3, 0, 0, 16'h0,    4'b0111, BZ,    0);
        add(0, 0, 1, 16'hABCE, 4'b0111, BZ,    0);  // k=125 codes 10..14
        add(2, 0, 0, 16'h0,    4'b1110, 4'd14, 1);  // k=128
        add(3, 0, 0, 16'h0,    4'b1101, 4'd12, 0);
        add(3, 0, 0, 16'h0,    4'b1011, 4'd11, 0);
        add(3, 0, 0, 16'h0,    4'b0111, 4'd10, 0);
        add(8, 0, 1, 16'h9999, 4'b1101, 4'd12, 0);  // k=149 pending loaded
        add(3, 1, 0, 16'h0,    4'b1110, 4'd15, 0);  // k=153 reset while idx=2
        add(0, 0, 0, 16'h0,    4'b1110, 4'd15, 0);  // r=1 restart at digit 0
        add(2, 0, 0, 16'h0,    4'b1101, 4'd15, 0);  // r=4
        add(11, 0, 0, 16'h0,   4'b1110, 4'd15, 1);  // r=16 pending discarded
        add(3, 0, 0, 16'h0,    4'b1101, 4'd15, 0);  // r=20

        // Reset, with a load during reset that must be ignored.
        step(1, 0, 16'h0);
        step(1, 1, 16'h1234);
        chk_all(0, 4'b1110, 4'd15, 1'b0);

        // Idle scan for 40 cycles.
        for (int k = 1; k <= 40; k++) begin
            logic [1:0] ix;
            step(0, 0, 16'h0);
            ix = 2'((k / 4) % 4);
            chk_all(k, ~(4'b0001 << ix), 4'd15, (k % 16) == 0);
        end

        for (int n = 0; n < vq.size(); n++) begin
            for (int unsigned j = 0; j < vq[n].idle; j++) step(0, 0, 16'h0);
            step(vq[n].rst, vq[n].load, vq[n].digits);
            chk_all(1000 + n, vq[n].ctl, vq[n].in, vq[n].fd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ssd_scan_ctrl.md
SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk drives all state, rst is sampled only on the rising edge of clk.
REQ-002 The block SHALL provide parameter DIV_MAX, default 100000, giving the scan-tick period in clk cycles; legal range is 2 to 2^20.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 The block SHALL have port digits, input, 16 bits: four BCD codes; [3:0] is digit 0 (rightmost) and [15:12] is digit 3 (leftmost).
REQ-006 The block SHALL have port load, input, 1 bit: a one-cycle strobe that captures digits into the pending buffer.
REQ-007 The block SHALL have port ssd_in, output, 4 bits: the code of the currently scanned digit, fed to the downstream 7-segment decoder; 4'd15 means blank.
REQ-008 The block SHALL have port ssd_ctl, output, 4 bits: active-low digit enables, one-cold; bit k selects digit k.
REQ-009 The block SHALL have port frame_done, output, 1 bit: a one-cycle pulse at each frame wrap.

Function
REQ-010 The divider SHALL count 0..DIV_MAX-1, asserting an internal tick when the count equals DIV_MAX-1, and then wrap to 0.
REQ-011 On a tick, the 2-bit digit index idx SHALL advance 0->1->2->3->0.
REQ-012 ssd_ctl and ssd_in SHALL be registered and SHALL update on the same edge as idx: ssd_ctl = ~(4'b0001<<idx_new), ssd_in = disp[idx_new].
REQ-013 A load SHALL write digits into the pending register and set pend_valid.
REQ-014 On a tick where idx goes from 3 to 0 (the frame wrap), frame_done SHALL pulse high for exactly 1 cycle, and if pend_valid=1, disp SHALL take the pending value and pend_valid SHALL clear.
REQ-015 If load coincides with a frame wrap, disp SHALL take the incoming digits directly (bypass), and pend_valid SHALL end at 0.
REQ-016 Multiple loads within one frame SHALL keep only the last one.
REQ-017 disp SHALL never change except at a frame wrap, so no frame mixes old and new digits.
REQ-018 Codes 10..14 SHALL pass through unchanged; interpreting them is the decoder's job.
REQ-019 Digit 0 at ssd_in on the wrap edge SHALL be taken from the newly loaded disp value.

Reset
REQ-020 While rst=1 at a clk edge, the block SHALL set: divider=0, idx=0, disp=16'hFFFF, pending=16'hFFFF, pend_valid=0, ssd_ctl=4'b1110, ssd_in=4'd15, frame_done=0.
REQ-021 A reset asserted mid-frame SHALL discard the pending data and restart the scan at digit 0 on the next cycle after rst falls.
REQ-022 A load in the same cycle as rst=1 SHALL be ignored.

Configuration
REQ-023 With macro LEADING_ZERO_BLANK_EN defined, values written to disp SHALL pass through leading-zero blanking: digit 3 becomes 15 if it is 0; digit 2 becomes 15 if it is 0 and digit 3 was blanked; digit 1 follows the same rule against digit 2; digit 0 is never blanked.
REQ-024 Without LEADING_ZERO_BLANK_EN, disp SHALL receive digits unmodified; no blanking logic shall be present.

Verification (bench uses DIV_MAX=4)
REQ-025 Release reset and hold load=0 for 40 cycles -> ssd_ctl cycles 1110,1101,1011,0111 with each value lasting 4 cycles, ssd_in=15 throughout, and frame_done pulses every 16 cycles.
REQ-026 Pulse load with digits=16'h1234 mid-frame -> displayed values are unchanged until the wrap; from the wrap onward ssd_in reads 4,3,2,1 on digits 0..3.
REQ-027 Apply load with 16'h5678 on the exact wrap cycle -> the frame that starts shows 8,7,6,5, and pend_valid=0 afterwards.
REQ-028 Load 16'h1111 then 16'h2222 within one frame -> the next frame shows only 2,2,2,2.
REQ-029 With LEADING_ZERO_BLANK_EN, load 16'h0070 -> ssd_in reads 0,7,15,15; load 16'h0000 -> ssd_in reads 0,15,15,15. Without the macro, 16'h0070 reads 0,7,0,0.
REQ-030 Assert rst for 1 cycle while idx=2 with pending loaded -> outputs return to 1110/15, and the pending data never appears.
